clk_div_gen: RTL and testbench

CLK_DIV_GEN -- requirements
Module: clk_div_gen

---
 rtl/clk_div_gen_pkg.sv | 12 +
 rtl/clk_div_gen_ch.sv | 117 +++++++++++
 rtl/clk_div_gen.sv | 51 +++++
 tb/tb_clk_div_gen.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_gen_pkg.sv
// Shared defaults and channel state type for the clock divider generator.
package clk_div_gen_pkg;

  localparam int unsigned DIV_W_DEF       = 8;
  localparam int unsigned DEFAULT_DIV_DEF = 7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ch_state_e;

endpackage

// File: rtl/clk_div_gen_ch.sv
// One divider channel (module clk_div_ch): IDLE/RUN FSM, counter, staged divide value.
// Optional macro CLK_DIV_SYNC_EN adds sync_i for phase realignment of running channels.
module clk_div_ch
  import clk_div_gen_pkg::*;
#(
  parameter int unsigned DIV_W       = DIV_W_DEF,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             we_i,
  input  logic [DIV_W-1:0] div_i,
`ifdef CLK_DIV_SYNC_EN
  input  logic             sync_i,
`endif
  output logic             div_clk_o,
  output logic             rise_o,
  output logic             run_o,
  output logic             pend_o
);

  ch_state_e        state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] stg_q, stg_d;
  logic             clk_q, clk_d;
  logic             rise_q, rise_d;
  logic             pend_q, pend_d;
  logic             sync;

`ifdef CLK_DIV_SYNC_EN
  assign sync = sync_i;
`else
  assign sync = 1'b0;
`endif

  // Next-state: a running channel only stops or picks up a staged D on its falling toggle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    stg_d   = stg_q;
    clk_d   = clk_q;
    rise_d  = 1'b0;
    pend_d  = pend_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        clk_d = 1'b0;
        if (we_i) div_d = div_i;
        if (en_i) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (sync) begin
          cnt_d  = '0;
          clk_d  = 1'b0;
          pend_d = 1'b0;
          if (we_i)        div_d = div_i;
          else if (pend_q) div_d = stg_q;
        end else begin
          if (cnt_q == div_q) begin
            cnt_d  = '0;
            clk_d  = ~clk_q;
            rise_d = ~clk_q;
            if (clk_q) begin
              if (pend_q) begin
                div_d  = stg_q;
                pend_d = 1'b0;
              end
              if (!en_i) state_d = ST_IDLE;
            end
          end else begin
            cnt_d = cnt_q + DIV_W'(1);
          end
          // A write landing on the stop edge goes straight into D, the channel is now idle.
          if (we_i) begin
            if (state_d == ST_IDLE) begin
              div_d  = div_i;
              pend_d = 1'b0;
            end else begin
              stg_d  = div_i;
              pend_d = 1'b1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      div_q   <= DIV_W'(DEFAULT_DIV);
      stg_q   <= DIV_W'(DEFAULT_DIV);
      clk_q   <= 1'b0;
      rise_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      stg_q   <= stg_d;
      clk_q   <= clk_d;
      rise_q  <= rise_d;
      pend_q  <= pend_d;
    end
  end

  assign div_clk_o = clk_q;
  assign rise_o    = rise_q;
  assign run_o     = (state_q == ST_RUN);
  assign pend_o    = pend_q;

endmodule

// File: rtl/clk_div_gen.sv
// Multi-channel clock divider: configuration write decode and per-channel instances.
// Optional macro CLK_DIV_SYNC_EN adds the sync_i realignment input.
module clk_div_gen
  import clk_div_gen_pkg::*;
#(
  parameter  int unsigned NUM_CH      = 4,
  parameter  int unsigned DIV_W       = DIV_W_DEF,
  parameter  int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF,
  localparam int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_en_i,
  input  logic              cfg_we_i,
  input  logic [CH_W-1:0]   cfg_ch_i,
  input  logic [DIV_W-1:0]  cfg_div_i,
`ifdef CLK_DIV_SYNC_EN
  input  logic              sync_i,
`endif
  output logic [NUM_CH-1:0] div_clk_o,
  output logic [NUM_CH-1:0] rise_o,
  output logic [NUM_CH-1:0] run_o,
  output logic [NUM_CH-1:0] pend_o
);

  logic [NUM_CH-1:0] ch_we;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Out-of-range channel numbers never match any instance.
    assign ch_we[i] = cfg_we_i && (32'(cfg_ch_i) == i);

    clk_div_ch #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .en_i      (ch_en_i[i]),
      .we_i      (ch_we[i]),
      .div_i     (cfg_div_i),
`ifdef CLK_DIV_SYNC_EN
      .sync_i    (sync_i),
`endif
      .div_clk_o (div_clk_o[i]),
      .rise_o    (rise_o[i]),
      .run_o     (run_o[i]),
      .pend_o    (pend_o[i])
    );
  end

endmodule

// File: tb/tb_clk_div_gen.sv
// Bench for clk_div_gen: vector table, directed corner sequences and a random run
// checked against a period/phase arithmetic model of each channel.
module tb_clk_div_gen;

  localparam int NUM_CH = 3;
  localparam int DIV_W  = 8;
  localparam int CH_W   = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NUM_CH-1:0] en_r = '0;
  logic              we_r = 1'b0;
  logic [CH_W-1:0]   ch_r = '0;
  logic [DIV_W-1:0]  div_r = '0;
  logic              sync_r = 1'b0;
  logic [NUM_CH-1:0] div_clk_o, rise_o, run_o, pend_o;

  int checks = 0;
  int errors = 0;

  clk_div_gen #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .DEFAULT_DIV(7)) dut (
    .clk       (clk),
    .rst       (rst),
    .ch_en_i   (en_r),
    .cfg_we_i  (we_r),
    .cfg_ch_i  (ch_r),
    .cfg_div_i (div_r),
`ifdef CLK_DIV_SYNC_EN
    .sync_i    (sync_r),
`endif
    .div_clk_o (div_clk_o),
    .rise_o    (rise_o),
    .run_o     (run_o),
    .pend_o    (pend_o)
  );

  always #5 clk = ~clk;

  // Model: a running channel is a square wave of period 2(D+1) started at edge m_start.
  int m_d    [NUM_CH];
  int m_stg  [NUM_CH];
  int m_start[NUM_CH];
  bit m_run  [NUM_CH];
  bit m_pend [NUM_CH];
  int n_edge = 0;

  always @(posedge clk) begin
    n_edge++;
    if (!rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        bit wc;
        int e, p;
        wc = we_r && (int'(ch_r) == c);
        if (m_run[c]) begin
          e = n_edge - m_start[c];
          p = 2 * (m_d[c] + 1);
          if (sync_r) begin
            if (m_pend[c]) m_d[c] = m_stg[c];
            m_pend[c]  = 1'b0;
            m_start[c] = n_edge;
            if (wc) m_d[c] = int'(div_r);
          end else begin
            if (e > 0 && (e % p) == 0) begin
              if (m_pend[c]) begin
                m_d[c]    = m_stg[c];
                m_pend[c] = 1'b0;
              end
              if (!en_r[c]) m_run[c] = 1'b0;
              m_start[c] = n_edge;
            end
            if (wc) begin
              if (!m_run[c]) m_d[c] = int'(div_r);
              else begin
                m_stg[c]  = int'(div_r);
                m_pend[c] = 1'b1;
              end
            end
          end
        end else begin
          if (wc) m_d[c] = int'(div_r);
          if (en_r[c]) begin
            m_run[c]   = 1'b1;
            m_start[c] = n_edge;
          end
        end
      end
    end
  end

  function automatic void model_out(output logic [NUM_CH-1:0] ec, output logic [NUM_CH-1:0] er,
                                    output logic [NUM_CH-1:0] eu, output logic [NUM_CH-1:0] ep);
    for (int c = 0; c < NUM_CH; c++) begin
      int ph;
      ec[c] = 1'b0; er[c] = 1'b0; eu[c] = m_run[c]; ep[c] = m_pend[c];
      if (m_run[c]) begin
        ph    = (n_edge - m_start[c]) % (2 * (m_d[c] + 1));
        ec[c] = (ph >= m_d[c] + 1);
        er[c] = (ph == m_d[c] + 1);
      end
    end
  endfunction

  task automatic chk(input string name, input logic [NUM_CH-1:0] act, input logic [NUM_CH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%b want=%b", name, $time, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, act, exp);
    end
  endtask

  // One clock edge; outputs compared with the model 1 time unit later.
  task automatic step();
    logic [NUM_CH-1:0] ec, er, eu, ep;
    @(posedge clk);
    #1;
    model_out(ec, er, eu, ep);
    chk("model_div_clk", div_clk_o, ec);
    chk("model_rise",    rise_o,    er);
    chk("model_run",     run_o,     eu);
    chk("model_pend",    pend_o,    ep);
    we_r   = 1'b0;
    sync_r = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_div_clk", div_clk_o, '0);
    chk("rst_rise",    rise_o,    '0);
    chk("rst_run",     run_o,     '0);
    chk("rst_pend",    pend_o,    '0);
    for (int c = 0; c < NUM_CH; c++) begin
      m_run[c] = 1'b0; m_pend[c] = 1'b0; m_d[c] = 7; m_stg[c] = 7; m_start[c] = 0;
    end
    step();
    rst = 1'b0;
  endtask

  task automatic write_cfg(input int c, input int d);
    we_r  = 1'b1;
    ch_r  = CH_W'(c);
    div_r = DIV_W'(d);
    step();
  endtask

  task automatic edges_until_rise(input int c, input int budget, output int k);
    k = 0;
    do begin
      step();
      k++;
    end while (!rise_o[c] && k < budget);
  endtask

  typedef struct {
    logic [NUM_CH-1:0] en;
    logic              we;
    logic [CH_W-1:0]   ch;
    logic [DIV_W-1:0]  dv;
    logic [NUM_CH-1:0] e_clk;
    logic [NUM_CH-1:0] e_rise;
    logic [NUM_CH-1:0] e_run;
    logic [NUM_CH-1:0] e_pend;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int k, hi;

    // ch1 at D=0 (clk/2), then stop; a write to channel 3 must be ignored
    tbl[0] = '{3'b000, 1'b1, 2'd1, 8'd0, 3'b000, 3'b000, 3'b000, 3'b000};
    tbl[1] = '{3'b010, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000, 3'b010, 3'b000};
    tbl[2] = '{3'b010, 1'b0, 2'd0, 8'd0, 3'b010, 3'b010, 3'b010, 3'b000};
    tbl[3] = '{3'b010, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000, 3'b010, 3'b000};
    tbl[4] = '{3'b010, 1'b0, 2'd0, 8'd0, 3'b010, 3'b010, 3'b010, 3'b000};
    tbl[5] = '{3'b010, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000, 3'b010, 3'b000};
    tbl[6] = '{3'b000, 1'b0, 2'd0, 8'd0, 3'b010, 3'b010, 3'b010, 3'b000};
    tbl[7] = '{3'b000, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000, 3'b000, 3'b000};
    tbl[8] = '{3'b000, 1'b1, 2'd3, 8'd5, 3'b000, 3'b000, 3'b000, 3'b000};
    tbl[9] = '{3'b111, 1'b0, 2'd0, 8'd0, 3'b000, 3'b000, 3'b111, 3'b000};

    do_reset();
    step();

    // Defaults on ch0: first rise 8 edges after RUN, then every 16, one-cycle strobe
    en_r = 3'b001;
    step();
    edges_until_rise(0, 40, k);
    chk_int("first_rise_d7", k, 8);
    step();
    chk_int("rise_one_cycle", int'(rise_o[0]), 0);
    edges_until_rise(0, 40, k);
    chk_int("period_d7_a", k + 1, 16);
    edges_until_rise(0, 40, k);
    chk_int("period_d7_b", k, 16);

    // Drop enable one cycle after a rise: high phase still lasts 8 cycles
    step();
    en_r = 3'b000;
    hi = 2;
    for (int i = 0; i < 40; i++) begin
      step();
      if (div_clk_o[0]) hi++;
      else break;
    end
    chk_int("stop_high_len", hi, 8);
    chk_int("stop_run", int'(run_o[0]), 0);
    repeat (20) step();
    chk_int("stop_low", int'(div_clk_o[0]), 0);

    // Table: D=0 on ch1 and an ignored out-of-range write
    do_reset();
    for (int i = 0; i < 10; i++) begin
      en_r  = tbl[i].en;
      we_r  = tbl[i].we;
      ch_r  = tbl[i].ch;
      div_r = tbl[i].dv;
      step();
      chk($sformatf("tbl%0d_clk", i),  div_clk_o, tbl[i].e_clk);
      chk($sformatf("tbl%0d_rise", i), rise_o,    tbl[i].e_rise);
      chk($sformatf("tbl%0d_run", i),  run_o,     tbl[i].e_run);
      chk($sformatf("tbl%0d_pend", i), pend_o,    tbl[i].e_pend);
    end
    en_r = '0;

    // ch2 at D=3, retarget to D=1 in the middle of a high phase
    do_reset();
    write_cfg(2, 3);
    en_r = 3'b100;
    step();
    edges_until_rise(2, 40, k);
    chk_int("ch2_first_rise", k, 4);
    step();
    write_cfg(2, 1);
    chk_int("ch2_pend_set", int'(pend_o[2]), 1);
    step();
    chk_int("ch2_pend_hold", int'(pend_o[2]), 1);
    chk_int("ch2_still_high", int'(div_clk_o[2]), 1);
    step();
    chk_int("ch2_pend_clear", int'(pend_o[2]), 0);
    chk_int("ch2_fell", int'(div_clk_o[2]), 0);
    edges_until_rise(2, 40, k);
    chk_int("ch2_new_first", k, 2);
    edges_until_rise(2, 40, k);
    chk_int("ch2_new_period", k, 4);

    // Reset mid-period with a staged value: D returns to 7
    do_reset();
    write_cfg(0, 5);
    en_r = 3'b001;
    repeat (4) step();
    write_cfg(0, 2);
    chk_int("staged_pend", int'(pend_o[0]), 1);
    en_r = 3'b000;
    do_reset();
    en_r = 3'b001;
    step();
    edges_until_rise(0, 40, k);
    chk_int("post_rst_d7", k, 8);

    // Maximum divide value
    do_reset();
    write_cfg(1, 255);
    en_r = 3'b010;
    step();
    edges_until_rise(1, 600, k);
    chk_int("dmax_first", k, 256);
    edges_until_rise(1, 600, k);
    chk_int("dmax_period", k, 512);

`ifdef CLK_DIV_SYNC_EN
    // Sync aligns ch0 (D=1) and ch1 (D=3)
    do_reset();
    write_cfg(0, 1);
    write_cfg(1, 3);
    en_r = 3'b011;
    repeat (5) step();
    sync_r = 1'b1;
    step();
    chk_int("sync_clk0", int'(div_clk_o[0]), 0);
    chk_int("sync_clk1", int'(div_clk_o[1]), 0);
    for (int e = 1; e <= 12; e++) begin
      step();
      chk_int($sformatf("sync_rise0_e%0d", e), int'(rise_o[0]), int'(e >= 2 && (e - 2) % 4 == 0));
      chk_int($sformatf("sync_rise1_e%0d", e), int'(rise_o[1]), int'(e >= 4 && (e - 4) % 8 == 0));
    end
`endif

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) en_r = NUM_CH'($urandom);
      we_r  = ($urandom_range(0, 3) == 0);
      ch_r  = CH_W'($urandom_range(0, 3));
      div_r = ($urandom_range(0, 15) == 0) ? DIV_W'($urandom_range(0, 40)) : DIV_W'($urandom_range(0, 6));
`ifdef CLK_DIV_SYNC_EN
      sync_r = ($urandom_range(0, 31) == 0);
`endif
      if ($urandom_range(0, 999) == 0) do_reset();
      else step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
